fib_seq_gen: RTL and testbench
==============================

Name: fib_seq_gen

Overview:
- Parametrised, seedable Fibonacci-type sequence generator: F(n+1) = F(n) + F(n-1) with programmable F(0)/F(1) seeds.
- Covers Fibonacci (0,1), Lucas (2,1) and arbitrary seed pairs.
- Start/step control, term index, programmable term limit, and overflow detection with stop or wrap policy.
- Used as a stimulus/number source feeding display and arithmetic blocks in the lab designs.

Parameters:
- WIDTH, 10: bit width of every sequence term.
- IDX_BITS, 6: bit width of the term index and term limit.

Ports:
- clk  input  1  rising-edge clock.
- nrst  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; loads seeds and enters RUN.
- seed0  input  WIDTH  F(0), sampled on start.
- seed1  input  WIDTH  F(1), sampled on start.
- wrap_mode  input  1  sampled on start; 0 = stop on overflow, 1 = continue modulo 2^WIDTH.
- max_idx  input  IDX_BITS  last term index to produce, sampled on start.
- step  input  1  advance one term when in RUN.
- f_out  output  WIDTH  current term F(n_idx).
- n_idx  output  IDX_BITS  index of the current term.
- f_valid  output  1  high while f_out holds a term of the current run.
- busy  output  1  high in RUN.
- done  output  1  sticky high in HALT.
- ovf  output  1  sticky overflow flag for the current run.

Behaviour:
- Reset (async, nrst=0): state=IDLE; f_out=0, n_idx=0, f_valid=0, busy=0, done=0, ovf=0, and all internal registers 0.
- Internal registers:
  - cur drives f_out.
  - nxt holds F(n+1).
  - nxt_bad flags that nxt is truncated; nxt_bad = carry out of the WIDTH+1-bit sum that produced nxt.
  - Latched copies of wrap_mode and max_idx.
- States: IDLE, RUN, HALT.
- IDLE --start--> RUN on the next edge:
  - cur=seed0, nxt=seed1, nxt_bad=0, n_idx=0, f_valid=1, busy=1, done=0, ovf=0.
  - Latency from start to first valid term is 1 cycle.
- RUN with step=1, one term per cycle:
  - If n_idx==max_idx or n_idx==2^IDX_BITS-1: go to HALT; done=1, busy=0; f_out and n_idx hold. The step is consumed but produces no term.
  - Else if nxt_bad=1 and wrap=0: go to HALT; ovf=1, done=1; f_out holds the last valid term and n_idx is unchanged.
  - Else advance: cur<=nxt, nxt<=(cur+nxt) mod 2^WIDTH, nxt_bad<=carry, n_idx<=n_idx+1. If nxt_bad was 1 (wrap=1), also set ovf=1.
- RUN with step=0: all registers hold.
- HALT: f_valid stays 1; all registers hold until start or reset.
- start in any state, including mid-RUN, restarts from the new seeds; start has priority over step in the same cycle.
- step in IDLE or HALT is ignored.
- max_idx=0: the first step goes directly to HALT with f_out=seed0.
- Seeds are not range-checked; seed1 < seed0 is legal.
- Reset mid-run returns immediately to the reset values above.

Optional Feature:
- Macro FIB_SATURATE_EN.
- Defined: in wrap mode, an advance with nxt_bad=1 loads f_out=2^WIDTH-1 and sets ovf=1. From then on each step keeps f_out=2^WIDTH-1 and still increments n_idx, up to the max_idx stop.
- Not defined: wrap mode produces truncated modulo-2^WIDTH terms exactly as described in Behaviour.
- Stop mode (wrap_mode=0) is identical with and without the macro.

Test Plan:
1. Reset, then start with seed0=0, seed1=1, wrap=0, max_idx=40, then step every cycle (WIDTH=10) -> f_out sequence 0,1,1,2,3,5,...,610,987. At n_idx=16 (f_out=987), the next step gives done=1, ovf=1, f_out stays 987, n_idx stays 16.
2. Same stimulus with wrap=1, macro undefined -> term 17 is 573 (1597-1024), ovf=1, busy=1; term 18 is (987+573) mod 1024 = 536.
3. Lucas run: seed0=2, seed1=1, max_idx=5 -> f_out 2,1,3,4,7,11 at n_idx 0..5; the next step gives done=1 with f_out=11, ovf=0.
4. Pulse start at n_idx=7 of a Fibonacci run with seeds 5,8 while step=1 -> next cycle f_out=5, n_idx=0, ovf=0, done=0; the step in that cycle is ignored.
5. Drop nrst at n_idx=4 mid-run -> outputs go to 0 immediately, without waiting for a clock; after release, step has no effect until start.
6. With FIB_SATURATE_EN defined, repeat scenario 2 -> term 17 is 1023, terms 18 and later stay 1023, n_idx keeps incrementing, ovf=1.

Source files
------------

// File: rtl/fib_seq_gen.sv
// Seedable Fibonacci-type sequence generator with term limit and overflow stop/wrap policy.
// Optional macro FIB_SATURATE_EN: wrap mode saturates at 2^WIDTH-1 instead of truncating.
module fib_seq_gen #(
  parameter int WIDTH    = 10,
  parameter int IDX_BITS = 6
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                start,
  input  logic [WIDTH-1:0]    seed0,
  input  logic [WIDTH-1:0]    seed1,
  input  logic                wrap_mode,
  input  logic [IDX_BITS-1:0] max_idx,
  input  logic                step,
  output logic [WIDTH-1:0]    f_out,
  output logic [IDX_BITS-1:0] n_idx,
  output logic                f_valid,
  output logic                busy,
  output logic                done,
  output logic                ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t              state_r, state_s;
  logic [WIDTH-1:0]    cur_r, cur_s;
  logic [WIDTH-1:0]    nxt_r, nxt_s;
  logic                nxt_bad_r, nxt_bad_s;
  logic [IDX_BITS-1:0] n_idx_r, n_idx_s;
  logic                f_valid_r, f_valid_s;
  logic                busy_r, busy_s;
  logic                done_r, done_s;
  logic                ovf_r, ovf_s;
  logic                wrap_r, wrap_s;
  logic [IDX_BITS-1:0] max_r, max_s;
`ifdef FIB_SATURATE_EN
  logic                sat_r, sat_s;
`endif

  // The carry of this WIDTH+1-bit sum marks the next term as truncated
  logic [WIDTH:0]      sum_s;
  logic                at_limit_s;

  assign sum_s      = {1'b0, cur_r} + {1'b0, nxt_r};
  assign at_limit_s = (n_idx_r == max_r) || (n_idx_r == {IDX_BITS{1'b1}});

  // Next-state and next-register computation; start wins over step in every state
  always_comb begin
    state_s   = state_r;
    cur_s     = cur_r;
    nxt_s     = nxt_r;
    nxt_bad_s = nxt_bad_r;
    n_idx_s   = n_idx_r;
    f_valid_s = f_valid_r;
    busy_s    = busy_r;
    done_s    = done_r;
    ovf_s     = ovf_r;
    wrap_s    = wrap_r;
    max_s     = max_r;
`ifdef FIB_SATURATE_EN
    sat_s     = sat_r;
`endif
    if (start) begin
      state_s   = RUN;
      cur_s     = seed0;
      nxt_s     = seed1;
      nxt_bad_s = 1'b0;
      n_idx_s   = {IDX_BITS{1'b0}};
      f_valid_s = 1'b1;
      busy_s    = 1'b1;
      done_s    = 1'b0;
      ovf_s     = 1'b0;
      wrap_s    = wrap_mode;
      max_s     = max_idx;
`ifdef FIB_SATURATE_EN
      sat_s     = 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          state_s = IDLE;
        end
        RUN: begin
          if (!step) begin
            state_s = RUN;
          end else if (at_limit_s) begin
            state_s = HALT;
            done_s  = 1'b1;
            busy_s  = 1'b0;
          end else if (nxt_bad_r && !wrap_r) begin
            // Stop policy: keep the last valid term on the output
            state_s = HALT;
            ovf_s   = 1'b1;
            done_s  = 1'b1;
            busy_s  = 1'b0;
          end else begin
            nxt_s     = sum_s[WIDTH-1:0];
            nxt_bad_s = sum_s[WIDTH];
            n_idx_s   = n_idx_r + {{(IDX_BITS-1){1'b0}}, 1'b1};
`ifdef FIB_SATURATE_EN
            if (nxt_bad_r || sat_r) begin
              cur_s = {WIDTH{1'b1}};
              sat_s = 1'b1;
              ovf_s = 1'b1;
            end else begin
              cur_s = nxt_r;
            end
`else
            cur_s = nxt_r;
            if (nxt_bad_r) begin
              ovf_s = 1'b1;
            end else begin
              ovf_s = ovf_r;
            end
`endif
          end
        end
        HALT: begin
          state_s = HALT;
        end
        default: begin
          state_s   = IDLE;
          f_valid_s = 1'b0;
          busy_s    = 1'b0;
          done_s    = 1'b0;
        end
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_r   <= IDLE;
      cur_r     <= {WIDTH{1'b0}};
      nxt_r     <= {WIDTH{1'b0}};
      nxt_bad_r <= 1'b0;
      n_idx_r   <= {IDX_BITS{1'b0}};
      f_valid_r <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      ovf_r     <= 1'b0;
      wrap_r    <= 1'b0;
      max_r     <= {IDX_BITS{1'b0}};
`ifdef FIB_SATURATE_EN
      sat_r     <= 1'b0;
`endif
    end else begin
      state_r   <= state_s;
      cur_r     <= cur_s;
      nxt_r     <= nxt_s;
      nxt_bad_r <= nxt_bad_s;
      n_idx_r   <= n_idx_s;
      f_valid_r <= f_valid_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
      ovf_r     <= ovf_s;
      wrap_r    <= wrap_s;
      max_r     <= max_s;
`ifdef FIB_SATURATE_EN
      sat_r     <= sat_s;
`endif
    end
  end

  assign f_out   = cur_r;
  assign n_idx   = n_idx_r;
  assign f_valid = f_valid_r;
  assign busy    = busy_r;
  assign done    = done_r;
  assign ovf     = ovf_r;

endmodule

// File: tb/tb_fib_seq_gen.sv
// Directed self-checking bench for fib_seq_gen (WIDTH=10, IDX_BITS=6).
// Define FIB_SATURATE_EN for both files to exercise the saturating wrap variant.
module tb_fib_seq_gen;
  localparam int W  = 10;
  localparam int IB = 6;

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  seed0 = '0;
  logic [W-1:0]  seed1 = '0;
  logic          wrap_mode = 1'b0;
  logic [IB-1:0] max_idx = '0;
  logic          step = 1'b0;
  logic [W-1:0]  f_out;
  logic [IB-1:0] n_idx;
  logic          f_valid, busy, done, ovf;

  int n_chk = 0;
  int n_err = 0;

  logic [W-1:0] fib [0:16] = '{10'd0, 10'd1, 10'd1, 10'd2, 10'd3, 10'd5, 10'd8, 10'd13, 10'd21,
                               10'd34, 10'd55, 10'd89, 10'd144, 10'd233, 10'd377, 10'd610, 10'd987};
  logic [W-1:0] luc [0:5]  = '{10'd2, 10'd1, 10'd3, 10'd4, 10'd7, 10'd11};

  always #5 clk = ~clk;

  fib_seq_gen #(.WIDTH(W), .IDX_BITS(IB)) dut (
    .clk(clk), .nrst(nrst), .start(start), .seed0(seed0), .seed1(seed1),
    .wrap_mode(wrap_mode), .max_idx(max_idx), .step(step),
    .f_out(f_out), .n_idx(n_idx), .f_valid(f_valid), .busy(busy), .done(done), .ovf(ovf)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [W-1:0] s0, input logic [W-1:0] s1,
                          input logic w, input logic [IB-1:0] m);
    seed0 = s0; seed1 = s1; wrap_mode = w; max_idx = m;
    start = 1'b1; step = 1'b0;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset;
    nrst = 1'b0;
    #3;
    n_chk++;
    if ({f_out, n_idx, f_valid, busy, done, ovf} !== {W'(0), IB'(0), 4'b0000}) begin
      n_err++; $display("FAIL reset_state: got f=%0d n=%0d v%b b%b d%b o%b, want all 0", f_out, n_idx, f_valid, busy, done, ovf);
    end
    @(negedge clk);
    nrst = 1'b1;
    step = 1'b1;
    repeat (2) tick();
    n_chk++;
    if ({f_valid, busy, n_idx} !== {2'b00, IB'(0)}) begin
      n_err++; $display("FAIL idle_step: got v%b b%b n=%0d, want v0 b0 n=0", f_valid, busy, n_idx);
    end
    step = 1'b0;
  endtask

  task automatic test_fib_stop;
    do_start(10'd0, 10'd1, 1'b0, 6'd40);
    n_chk++;
    if ({f_out, n_idx, f_valid, busy, done, ovf} !== {W'(0), IB'(0), 4'b1100}) begin
      n_err++; $display("FAIL fib_first: got f=%0d n=%0d v%b b%b d%b o%b, want f=0 n=0 v1 b1 d0 o0", f_out, n_idx, f_valid, busy, done, ovf);
    end
    step = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      n_chk++;
      if (f_out !== fib[i] || n_idx !== IB'(i)) begin
        n_err++; $display("FAIL fib_term: got f=%0d n=%0d, want f=%0d n=%0d", f_out, n_idx, fib[i], i);
      end
    end
    tick();
    n_chk++;
    if ({f_out, n_idx, f_valid, busy, done, ovf} !== {10'd987, 6'd16, 4'b1011}) begin
      n_err++; $display("FAIL fib_ovf_stop: got f=%0d n=%0d v%b b%b d%b o%b, want f=987 n=16 v1 b0 d1 o1", f_out, n_idx, f_valid, busy, done, ovf);
    end
    tick();
    n_chk++;
    if ({f_out, n_idx, done} !== {10'd987, 6'd16, 1'b1}) begin
      n_err++; $display("FAIL halt_hold: got f=%0d n=%0d d%b, want f=987 n=16 d1", f_out, n_idx, done);
    end
    step = 1'b0;
  endtask

  task automatic test_fib_wrap;
    do_start(10'd0, 10'd1, 1'b1, 6'd40);
    step = 1'b1;
    repeat (16) tick();
    n_chk++;
    if (f_out !== 10'd987) begin
      n_err++; $display("FAIL wrap_t16: got f=%0d, want 987", f_out);
    end
`ifdef FIB_SATURATE_EN
    for (int i = 17; i <= 19; i++) begin
      tick();
      n_chk++;
      if ({f_out, n_idx, busy, done, ovf} !== {10'd1023, IB'(i), 3'b101}) begin
        n_err++; $display("FAIL sat_term: got f=%0d n=%0d b%b d%b o%b, want f=1023 n=%0d b1 d0 o1", f_out, n_idx, busy, done, ovf, i);
      end
    end
`else
    tick();
    n_chk++;
    if ({f_out, n_idx, busy, done, ovf} !== {10'd573, 6'd17, 3'b101}) begin
      n_err++; $display("FAIL wrap_t17: got f=%0d n=%0d b%b d%b o%b, want f=573 n=17 b1 d0 o1", f_out, n_idx, busy, done, ovf);
    end
    tick();
    n_chk++;
    if ({f_out, n_idx, ovf} !== {10'd536, 6'd18, 1'b1}) begin
      n_err++; $display("FAIL wrap_t18: got f=%0d n=%0d o%b, want f=536 n=18 o1", f_out, n_idx, ovf);
    end
`endif
    step = 1'b0;
  endtask

  task automatic test_lucas;
    do_start(10'd2, 10'd1, 1'b0, 6'd5);
    n_chk++;
    if (f_out !== luc[0]) begin
      n_err++; $display("FAIL lucas_first: got f=%0d, want 2", f_out);
    end
    step = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      n_chk++;
      if (f_out !== luc[i] || n_idx !== IB'(i)) begin
        n_err++; $display("FAIL lucas_term: got f=%0d n=%0d, want f=%0d n=%0d", f_out, n_idx, luc[i], i);
      end
    end
    tick();
    n_chk++;
    if ({f_out, n_idx, busy, done, ovf} !== {10'd11, 6'd5, 3'b010}) begin
      n_err++; $display("FAIL lucas_limit: got f=%0d n=%0d b%b d%b o%b, want f=11 n=5 b0 d1 o0", f_out, n_idx, busy, done, ovf);
    end
    step = 1'b0;
  endtask

  task automatic test_back_to_back;
    do_start(10'd0, 10'd1, 1'b0, 6'd40);
    step = 1'b1;
    repeat (7) tick();
    n_chk++;
    if ({f_out, n_idx} !== {10'd13, 6'd7}) begin
      n_err++; $display("FAIL restart_pre: got f=%0d n=%0d, want f=13 n=7", f_out, n_idx);
    end
    seed0 = 10'd5; seed1 = 10'd8; start = 1'b1;
    tick();
    start = 1'b0;
    n_chk++;
    if ({f_out, n_idx, busy, done, ovf} !== {10'd5, 6'd0, 3'b100}) begin
      n_err++; $display("FAIL restart_load: got f=%0d n=%0d b%b d%b o%b, want f=5 n=0 b1 d0 o0", f_out, n_idx, busy, done, ovf);
    end
    tick();
    n_chk++;
    if ({f_out, n_idx} !== {10'd8, 6'd1}) begin
      n_err++; $display("FAIL restart_step: got f=%0d n=%0d, want f=8 n=1", f_out, n_idx);
    end
    step = 1'b0;
  endtask

  task automatic test_max_zero;
    do_start(10'd9, 10'd4, 1'b0, 6'd0);
    step = 1'b1;
    tick();
    n_chk++;
    if ({f_out, n_idx, f_valid, busy, done, ovf} !== {10'd9, 6'd0, 4'b1010}) begin
      n_err++; $display("FAIL max_zero: got f=%0d n=%0d v%b b%b d%b o%b, want f=9 n=0 v1 b0 d1 o0", f_out, n_idx, f_valid, busy, done, ovf);
    end
    step = 1'b0;
  endtask

  task automatic test_reset_midrun;
    do_start(10'd0, 10'd1, 1'b0, 6'd40);
    step = 1'b1;
    repeat (4) tick();
    n_chk++;
    if ({f_out, n_idx} !== {10'd3, 6'd4}) begin
      n_err++; $display("FAIL midrun_pre: got f=%0d n=%0d, want f=3 n=4", f_out, n_idx);
    end
    #2 nrst = 1'b0;
    #1;
    n_chk++;
    if ({f_out, n_idx, f_valid, busy, done, ovf} !== {W'(0), IB'(0), 4'b0000}) begin
      n_err++; $display("FAIL async_reset: got f=%0d n=%0d v%b b%b d%b o%b, want all 0", f_out, n_idx, f_valid, busy, done, ovf);
    end
    @(negedge clk);
    nrst = 1'b1;
    repeat (3) tick();
    n_chk++;
    if ({f_out, n_idx, f_valid, busy} !== {W'(0), IB'(0), 2'b00}) begin
      n_err++; $display("FAIL post_reset_step: got f=%0d n=%0d v%b b%b, want f=0 n=0 v0 b0", f_out, n_idx, f_valid, busy);
    end
    step = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fib_stop();
    test_fib_wrap();
    test_lucas();
    test_back_to_back();
    test_max_zero();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
